// File: rtl/core_pkg.sv
// Shared constants and helpers for the data-memory access stage.
package core_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Alignment rule: halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/acknowledge data-memory bus between the access stage and memory.
interface mem_access_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/load_extender.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module load_extender
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] load_data
);

  logic [BYTE_W-1:0]   byte_sel;
  logic [2*BYTE_W-1:0] half_sel;

  // Lane select followed by sign or zero extension.
  always_comb begin
    byte_sel = rdata[BYTE_W-1:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[BYTE_W-1:0];
      2'd1:    byte_sel = rdata[2*BYTE_W-1:BYTE_W];
      2'd2:    byte_sel = rdata[3*BYTE_W-1:2*BYTE_W];
      default: byte_sel = rdata[4*BYTE_W-1:3*BYTE_W];
    endcase
    half_sel = addr_lo[1] ? rdata[31:2*BYTE_W] : rdata[2*BYTE_W-1:0];

    case (funct3)
      F3_B:    load_data = {{(32-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_BU:   load_data = {{(32-BYTE_W){1'b0}}, byte_sel};
      F3_H:    load_data = {{(32-2*BYTE_W){half_sel[2*BYTE_W-1]}}, half_sel};
      F3_HU:   load_data = {{(32-2*BYTE_W){1'b0}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: one req/ack bus transaction per start, core held via busy.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; inputs latched when it arrives
//   BUS     | dmem_req held, waiting for ack or timeout
//   DONE    | one-cycle completion; done, load_data and flags valid
module mem_access
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_WIDTH       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        access_fault,
  mem_access_if.master dmem
);

  localparam bit                  TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LOAD = TO_WIDTH'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [2:0]          f3_q;
  logic [1:0]          addr_lo_q;
  logic [31:0]         load_q;
  logic                mis_q, fault_q;
  logic [TO_WIDTH-1:0] to_cnt_q;

  logic        op_any, mis_chk, fault_chk, legal_load, legal_store, go_bus, to_expire;
  logic [31:0] wdata_c, load_ext;
  logic [3:0]  wstrb_c;

  assign op_any      = mem_read | mem_write;
  assign legal_load  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
  assign legal_store = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
  assign mis_chk     = op_any & is_misaligned(funct3, addr[1:0]);
  assign fault_chk   = op_any & ~mis_chk &
                       ((mem_read & mem_write) | (mem_read ? ~legal_load : ~legal_store));
  assign go_bus      = op_any & ~mis_chk & ~fault_chk;
  assign to_expire   = TO_EN && (to_cnt_q == TO_WIDTH'(1));

  // Store byte-lane replication and strobes; zero for loads.
  always_comb begin
    wdata_c = '0;
    wstrb_c = '0;
    if (mem_write) begin
      case (funct3)
        F3_B: begin
          wdata_c = {4{store_data[BYTE_W-1:0]}};
          wstrb_c = 4'b0001 << addr[1:0];
        end
        F3_H: begin
          wdata_c = {2{store_data[2*BYTE_W-1:0]}};
          wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
        end
        F3_W: begin
          wdata_c = store_data;
          wstrb_c = 4'b1111;
        end
        default: begin
          wdata_c = '0;
          wstrb_c = '0;
        end
      endcase
    end
  end

  load_extender u_load_extender (
    .rdata     (dmem.dmem_rdata),
    .funct3    (f3_q),
    .addr_lo   (addr_lo_q),
    .load_data (load_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and stall/completion outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = go_bus ? ST_BUS : ST_DONE;
      end
      ST_BUS: begin
        busy = 1'b1;
        if (dmem.dmem_ack || to_expire) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched request fields, bus drive, timeout down-counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q            <= '0;
      addr_lo_q       <= '0;
      load_q          <= '0;
      mis_q           <= 1'b0;
      fault_q         <= 1'b0;
      to_cnt_q        <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_wstrb <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_q      <= funct3;
            addr_lo_q <= addr[1:0];
            load_q    <= '0;
            mis_q     <= mis_chk;
            fault_q   <= fault_chk;
            if (go_bus) begin
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= mem_write;
              dmem.dmem_addr  <= {addr[31:2], 2'b00};
              dmem.dmem_wdata <= wdata_c;
              dmem.dmem_wstrb <= wstrb_c;
              to_cnt_q        <= TO_LOAD;
            end
          end
        end
        ST_BUS: begin
          if (dmem.dmem_ack || to_expire) begin
            // Ack wins over a timeout landing on the same edge.
            if (dmem.dmem_ack) begin
              if (!dmem.dmem_we) load_q <= load_ext;
            end else begin
              fault_q <= 1'b1;
            end
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_wstrb <= '0;
            to_cnt_q        <= '0;
          end else if (TO_EN) begin
            to_cnt_q <= to_cnt_q - TO_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign load_data    = done ? load_q : '0;
  assign misaligned   = done & mis_q;
  assign access_fault = done & fault_q;

endmodule
